// File: rtl/pcileech_com_pkg.sv
// pcileech_com_pkg: shared widths and packet type for the COM TX path
package pcileech_com_pkg;
    localparam int COM_TX_PKT_BITS  = 256;
    localparam int COM_TX_WORD_BITS = 32;
    localparam int COM_TX_WORDS     = 8;
    typedef logic [COM_TX_PKT_BITS-1:0] com_tx_pkt_t;
endpackage

// File: rtl/pcileech_led_stretch.sv
// pcileech_led_stretch: keeps an activity LED lit for a while after the last pulse
module pcileech_led_stretch #(
    parameter int HOLD_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_i,
    input  logic active_i,
    output logic led_o
);
    logic [HOLD_W-1:0] hold_q, hold_d;
    // reload to all ones on a pulse, otherwise count down and park at zero
    always_comb hold_d = pulse_i ? '1 : (hold_q != '0 ? hold_q - HOLD_W'(1) : hold_q);
    // hold counter register
    always_ff @(posedge clk) begin
        if (rst) hold_q <= '0;
        else     hold_q <= hold_d;
    end
    assign led_o = active_i || (hold_q != '0);
endmodule

// File: rtl/pcileech_com_tx_serializer.sv
// pcileech_com_tx_serializer: 256-bit packets into a ping-pong buffer, out as 32-bit words LSB first
module pcileech_com_tx_serializer
    import pcileech_com_pkg::*;
#(
    parameter int PARAM_LED_HOLD_LOG2 = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [COM_TX_PKT_BITS-1:0]  din,
    input  logic                        din_wr_en,
    output logic                        din_ready,
    output logic [COM_TX_WORD_BITS-1:0] dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        overflow,
    output logic [31:0]                 tx_words,
    output logic                        led_tx
);
    com_tx_pkt_t slot_q [2];
    logic        wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [1:0]  count_q, count_d;
    logic [2:0]  widx_q, widx_d;
    logic        overflow_q, overflow_d;
    logic [31:0] tx_words_q, tx_words_d;
    logic        wr, pop, last;

    assign din_ready  = count_q != 2'd2;
    assign dout_valid = count_q != 2'd0;
    assign wr         = din_wr_en && din_ready;
    assign pop        = dout_valid && dout_ready;
    assign last       = pop && (widx_q == 3'(COM_TX_WORDS - 1));
    assign dout       = dout_valid ? slot_q[rd_sel_q][{widx_q, 5'd0} +: COM_TX_WORD_BITS] : '0;
    assign overflow   = overflow_q;
    assign tx_words   = tx_words_q;

    // next state: a write and a final-word pop in one cycle cancel in count
    always_comb begin
        wr_sel_d   = wr_sel_q ^ wr;
        rd_sel_d   = rd_sel_q ^ last;
        widx_d     = pop ? widx_q + 3'd1 : widx_q;
        count_d    = count_q + {1'b0, wr} - {1'b0, last};
        overflow_d = overflow_q | (din_wr_en & ~din_ready);
        tx_words_d = tx_words_q + {31'd0, pop};
    end

    // control registers; reset discards any buffered packet
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            count_q    <= 2'd0;
            widx_q     <= 3'd0;
            overflow_q <= 1'b0;
            tx_words_q <= '0;
        end else begin
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            count_q    <= count_d;
            widx_q     <= widx_d;
            overflow_q <= overflow_d;
            tx_words_q <= tx_words_d;
        end
    end

    // slot storage is data only and is never reset
    always_ff @(posedge clk) begin
        if (wr && !rst) slot_q[wr_sel_q] <= din;
    end

    pcileech_led_stretch #(.HOLD_W(PARAM_LED_HOLD_LOG2)) u_led (
        .clk      (clk),
        .rst      (rst),
        .pulse_i  (pop && !rst),
        .active_i (dout_valid),
        .led_o    (led_tx)
    );
endmodule

// File: tb/tb_pcileech_com_tx_serializer.sv
// tb_pcileech_com_tx_serializer: random and directed stimulus against a word-queue model
module tb_pcileech_com_tx_serializer;
    localparam int LOG2     = 4;
    localparam int HOLD_CYC = (1 << LOG2) - 1;

    logic         clk = 1'b0, rst = 1'b1, din_wr_en = 1'b0, dout_ready = 1'b0;
    logic [255:0] din = '0;
    logic         din_ready, dout_valid, overflow, led_tx;
    logic [31:0]  dout, tx_words;

    int checks = 0, failures = 0;

    logic [31:0] mq[$];
    bit          m_ovf, m_popped, started;
    logic [31:0] m_tx;
    int          m_age;

    always #5 clk = ~clk;

    pcileech_com_tx_serializer #(.PARAM_LED_HOLD_LOG2(LOG2)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_wr_en  (din_wr_en),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow),
        .tx_words   (tx_words),
        .led_tx     (led_tx)
    );

    function automatic int occ();
        return (mq.size() + 7) / 8;
    endfunction

    function automatic logic [255:0] mkpkt(logic [31:0] base);
        logic [255:0] p;
        for (int i = 0; i < 8; i++) p[32*i +: 32] = base + 32'(i);
        return p;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        bit rdy;
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_tx = 0; m_popped = 0; m_age = 0; started = 1;
        end else if (started) begin
            rdy = occ() < 2;
            if (mq.size() != 0 && dout_ready) begin
                void'(mq.pop_front());
                m_tx++;
                m_popped = 1;
                m_age = 0;
            end else if (m_age < 100000) m_age++;
            if (din_wr_en && rdy) for (int i = 0; i < 8; i++) mq.push_back(din[32*i +: 32]);
            else if (din_wr_en) m_ovf = 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_din_ready", din_ready, occ() < 2);
            check("m_dout_valid", dout_valid, mq.size() != 0);
            check("m_dout", dout, mq.size() != 0 ? mq[0] : 32'd0);
            check("m_overflow", overflow, m_ovf);
            check("m_tx_words", tx_words, m_tx);
            check("m_led", led_tx, occ() != 0 || (m_popped && m_age < HOLD_CYC));
        end
    end

    initial begin
        repeat (3) tick();
        check("rst_din_ready", din_ready, 1);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_led", led_tx, 0);
        rst = 0; dout_ready = 1; din = mkpkt(32'hA0000000); din_wr_en = 1;
        tick();
        din_wr_en = 0;
        for (int k = 0; k < 8; k++) begin
            check("single_word", dout, 32'hA0000000 + 32'(k));
            tick();
        end
        check("single_done_valid", dout_valid, 0);
        check("single_tx_words", tx_words, 8);
        repeat (14) tick();
        check("led_hold_last", led_tx, 1);
        tick();
        check("led_hold_off", led_tx, 0);

        dout_ready = 0; din = mkpkt(32'hB0000000); din_wr_en = 1;
        tick();
        din = mkpkt(32'hC0000000);
        tick();
        check("bp_din_ready", din_ready, 0);
        din = mkpkt(32'hD0000000);
        tick();
        din_wr_en = 0;
        check("bp_overflow", overflow, 1);
        check("bp_dout", dout, 32'hB0000000);
        tick();
        check("bp_dout_stable", dout, 32'hB0000000);
        dout_ready = 1;
        for (int k = 0; k < 16; k++) begin
            check("bp_drain", dout, (k < 8 ? 32'hB0000000 : 32'hC0000000) + 32'(k % 8));
            tick();
        end
        check("bp_tx_words", tx_words, 24);

        rst = 1; tick(); rst = 0;
        check("rst_overflow", overflow, 0);
        for (int p = 0; p < 8; p++) begin
            din = mkpkt(32'hE0000000 + 32'(p * 16)); din_wr_en = 1;
            tick();
            din_wr_en = 0;
            for (int k = 0; k < 8; k++) begin
                check("stream_valid", dout_valid, 1);
                check("stream_ready", din_ready, 1);
                check("stream_word", dout, 32'hE0000000 + 32'(p * 16 + k));
                if (k < 7) tick();
            end
        end
        tick();
        check("stream_tx_words", tx_words, 64);
        check("stream_overflow", overflow, 0);

        dout_ready = 0; din = mkpkt(32'hF0000000); din_wr_en = 1;
        tick();
        din = mkpkt(32'hF1000000);
        tick();
        din_wr_en = 0; dout_ready = 1;
        for (int k = 0; k < 8; k++) begin
            check("full_word", dout, 32'hF0000000 + 32'(k));
            tick();
        end
        check("full_next_word0", dout, 32'hF1000000);
        repeat (8) tick();

        din = mkpkt(32'h11110000); din_wr_en = 1;
        tick();
        din_wr_en = 0;
        repeat (3) tick();
        check("mid_word3", dout, 32'h11110003);
        rst = 1; din = mkpkt(32'h33330000); din_wr_en = 1;
        tick();
        rst = 0; din_wr_en = 0;
        check("mid_rst_valid", dout_valid, 0);
        check("mid_rst_tx", tx_words, 0);
        check("mid_rst_dout", dout, 0);
        din = mkpkt(32'h22220000); din_wr_en = 1;
        tick();
        din_wr_en = 0;
        check("post_rst_word0", dout, 32'h22220000);
        repeat (10) tick();

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 8; i++) din[32*i +: 32] = $urandom();
            din_wr_en  = $urandom_range(0, 99) < 30;
            dout_ready = $urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 80 : 40);
            rst        = $urandom_range(0, 399) == 0;
            tick();
        end
        rst = 0; din_wr_en = 0; dout_ready = 1;
        repeat (20) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
